// File: rtl/front_panel.sv
// Front panel: debounced step button, step/run/pause sequencing, hex display source.
module front_panel #(
  parameter int N          = 8,
  parameter int P_SIZE     = 8,
  parameter int DIGITS     = 6,
  parameter int DEB_CYCLES = 16,
  parameter int RUN_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  nStep,
  input  logic                  modeRun,
  input  logic [1:0]            sel,
  input  logic                  blankEn,
  input  logic [N-1:0]          result,
  input  logic [P_SIZE-1:0]     pc,
  output logic                  cpuStep,
  output logic                  paused,
  output logic [15:0]           stepCount,
  output logic [DIGITS*4-1:0]   digit,
  output logic [DIGITS-1:0]     blank
);

  localparam int W  = DIGITS * 4;
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int VW = $clog2(RUN_DIV);

  typedef enum logic [1:0] {
    ST_STEP,
    ST_RUN,
    ST_PAUSE
  } mode_t;

  mode_t         r_state;
  mode_t         w_stateNext;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_stableN;
  logic [DW-1:0] r_debCnt;
  logic          r_pressEvt;
  logic [VW-1:0] r_div;
  logic [VW-1:0] w_divNext;
  logic          w_stepReq;
  logic          w_debFlip;
  logic [W-1:0]  w_src;
  logic [DIGITS-1:0] w_blank;

  // Levels below are raw polarity: 1 = released, 0 = pressed.
  assign w_debFlip = (r_sync2 != r_stableN) && (r_debCnt == DW'(DEB_CYCLES - 1));

  // Synchroniser, debounce and press-event pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_stableN  <= 1'b1;
      r_debCnt   <= '0;
      r_pressEvt <= 1'b0;
    end else begin
      r_sync1    <= nStep;
      r_sync2    <= r_sync1;
      r_pressEvt <= w_debFlip & r_stableN;
      if (r_sync2 == r_stableN) begin
        r_debCnt <= '0;
      end else if (w_debFlip) begin
        r_stableN <= ~r_stableN;
        r_debCnt  <= '0;
      end else begin
        r_debCnt <= r_debCnt + DW'(1);
      end
    end
  end

  // Mode state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_STEP;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next mode, divider and step request; leaving run mode wins over a coincident press
  always_comb begin
    w_stateNext = r_state;
    w_divNext   = r_div;
    w_stepReq   = 1'b0;
    if (!modeRun) begin
      w_stateNext = ST_STEP;
      w_divNext   = '0;
      w_stepReq   = r_pressEvt;
    end else begin
      case (r_state)
        ST_PAUSE: w_stateNext = r_pressEvt ? ST_RUN : ST_PAUSE;
        default:  w_stateNext = r_pressEvt ? ST_PAUSE : ST_RUN;
      endcase
      if (r_state != ST_PAUSE) begin
        w_stepReq = (r_div == VW'(RUN_DIV - 1));
        w_divNext = w_stepReq ? '0 : r_div + VW'(1);
      end
    end
  end

  assign paused = (r_state == ST_PAUSE);

  // Step pulse, divider and step counter; a pulse is never issued back-to-back
  always_ff @(posedge clk) begin
    if (rst) begin
      cpuStep   <= 1'b0;
      r_div     <= '0;
      stepCount <= '0;
    end else begin
      cpuStep   <= w_stepReq & ~cpuStep;
      r_div     <= w_divNext;
      stepCount <= stepCount + {15'd0, cpuStep};
    end
  end

  // Display source selection and leading-zero blanking
  always_comb begin
    w_src = '0;
    case (sel)
      2'd0: w_src = W'(result);
      2'd1: w_src = W'(pc);
      2'd2: w_src = W'(stepCount);
      2'd3: w_src = W'({pc, result});
      default: w_src = '0;
    endcase
    w_blank = '0;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      w_blank[i] = blankEn && ((w_src >> (4 * i)) == '0);
    end
  end

  // Registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= '0;
      blank <= '0;
    end else begin
      digit <= w_src;
      blank <= w_blank;
    end
  end

endmodule

// File: tb/tb_front_panel.sv
module tb_front_panel;

  localparam int N       = 8;
  localparam int P_SIZE  = 8;
  localparam int DIGITS  = 6;
  localparam int DEB     = 16;
  localparam int RUN_DIV = 4;
  localparam int W       = DIGITS * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              nStep = 1'b1;
  logic              modeRun = 1'b0;
  logic [1:0]        sel = 2'd0;
  logic              blankEn = 1'b0;
  logic [N-1:0]      result = '0;
  logic [P_SIZE-1:0] pc = '0;
  logic              cpuStep;
  logic              paused;
  logic [15:0]       stepCount;
  logic [W-1:0]      digit;
  logic [DIGITS-1:0] blank;

  front_panel #(
    .N(N), .P_SIZE(P_SIZE), .DIGITS(DIGITS), .DEB_CYCLES(DEB), .RUN_DIV(RUN_DIV)
  ) dut (
    .clk(clk), .rst(rst), .nStep(nStep), .modeRun(modeRun), .sel(sel),
    .blankEn(blankEn), .result(result), .pc(pc), .cpuStep(cpuStep),
    .paused(paused), .stepCount(stepCount), .digit(digit), .blank(blank)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  bit m_s1, m_s2;            // synchronised "pressed" samples
  bit m_stable;              // debounced "pressed"
  int m_disagree;            // consecutive samples disagreeing with m_stable
  bit m_press;
  bit m_paused;
  int m_phase;               // active run clocks modulo RUN_DIV
  bit m_step;
  logic [15:0] m_count;
  logic [W-1:0] m_digit;
  logic [DIGITS-1:0] m_blank;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ns1, ns2, nStable, nPress, nPaused, want, nStp;
    int nDis, nPhase, h;
    logic [W-1:0] src;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_disagree = 0; m_press = 0;
      m_paused = 0; m_phase = 0; m_step = 0; m_count = '0;
      m_digit = '0; m_blank = '0;
      return;
    end
    ns1 = ~nStep;
    ns2 = m_s1;
    nStable = m_stable;
    nPress = 0;
    nDis = 0;
    if (m_s2 != m_stable) begin
      nDis = m_disagree + 1;
      if (nDis == DEB) begin
        nStable = ~m_stable;
        nDis = 0;
        nPress = nStable;
      end
    end
    if (!modeRun) begin
      want = m_press;
      nPhase = 0;
      nPaused = 0;
    end else begin
      want = !m_paused && (((m_phase + 1) % RUN_DIV) == 0);
      nPhase = m_paused ? m_phase : (m_phase + 1) % RUN_DIV;
      nPaused = m_press ? ~m_paused : m_paused;
    end
    nStp = want && !m_step;
    case (sel)
      2'd0: src = W'(result);
      2'd1: src = W'(pc);
      2'd2: src = W'(m_count);
      default: src = W'({pc, result});
    endcase
    h = 0;
    for (int i = 0; i < DIGITS; i++) if (src[4*i +: 4] != 4'h0) h = i;
    for (int i = 0; i < DIGITS; i++) m_blank[i] = blankEn && (i > h);
    m_digit = src;
    m_count = m_count + (m_step ? 16'd1 : 16'd0);
    m_s1 = ns1; m_s2 = ns2; m_stable = nStable; m_disagree = nDis; m_press = nPress;
    m_paused = nPaused; m_phase = nPhase; m_step = nStp;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("cpuStep", 32'(cpuStep), 32'(m_step));
    check("paused", 32'(paused), 32'(m_paused));
    check("stepCount", 32'(stepCount), 32'(m_count));
    check("digit", 32'(digit), 32'(m_digit));
    check("blank", 32'(blank), 32'(m_blank));
  endtask

  typedef struct {
    logic [1:0] s;
    logic       be;
    logic [7:0] res;
    logic [7:0] p;
    logic [23:0] dig;
    logic [5:0] blk;
  } vec_t;

  vec_t vt[9];

  initial begin
    int pulses, last, first, hold;

    vt[0] = '{2'd3, 1'b1, 8'h34, 8'h12, 24'h001234, 6'b110000};
    vt[1] = '{2'd0, 1'b1, 8'h00, 8'h00, 24'h000000, 6'b111110};
    vt[2] = '{2'd0, 1'b1, 8'hAB, 8'h00, 24'h0000AB, 6'b111100};
    vt[3] = '{2'd1, 1'b1, 8'h77, 8'h05, 24'h000005, 6'b111110};
    vt[4] = '{2'd3, 1'b0, 8'h34, 8'h12, 24'h001234, 6'b000000};
    vt[5] = '{2'd3, 1'b1, 8'hFF, 8'hFF, 24'h00FFFF, 6'b110000};
    vt[6] = '{2'd0, 1'b0, 8'h00, 8'h00, 24'h000000, 6'b000000};
    vt[7] = '{2'd2, 1'b1, 8'h99, 8'h99, 24'h000000, 6'b111110};
    vt[8] = '{2'd0, 1'b1, 8'h10, 8'h00, 24'h000010, 6'b111100};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_cpuStep", 32'(cpuStep), 32'd0);
    check("rst_paused", 32'(paused), 32'd0);
    check("rst_stepCount", 32'(stepCount), 32'd0);
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_blank", 32'(blank), 32'd0);
    rst = 1'b0;

    // Display table
    foreach (vt[i]) begin
      sel = vt[i].s; blankEn = vt[i].be; result = vt[i].res; pc = vt[i].p;
      tick();
      check("tbl_digit", 32'(digit), 32'(vt[i].dig));
      check("tbl_blank", 32'(blank), 32'(vt[i].blk));
    end

    // Single press in step mode
    sel = 2'd2; modeRun = 1'b0; pulses = 0;
    nStep = 1'b0;
    repeat (40) begin tick(); if (cpuStep) pulses++; end
    nStep = 1'b1;
    repeat (40) begin tick(); if (cpuStep) pulses++; end
    check("step_pulses", 32'(pulses), 32'd1);
    check("step_count", 32'(stepCount), 32'd1);

    // Glitches shorter than the debounce period
    pulses = 0;
    repeat (5) begin
      nStep = 1'b0;
      repeat (10) begin tick(); if (cpuStep) pulses++; end
      nStep = 1'b1;
      repeat (10) begin tick(); if (cpuStep) pulses++; end
    end
    repeat (20) begin tick(); if (cpuStep) pulses++; end
    check("glitch_pulses", 32'(pulses), 32'd0);
    check("glitch_count", 32'(stepCount), 32'd1);

    // Free run, pause, resume
    rst = 1'b1; tick(); rst = 1'b0;
    modeRun = 1'b1; pulses = 0; last = -1; first = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (cpuStep) begin
        pulses++;
        if (first < 0) first = i;
        if (last >= 0) check("run_spacing", 32'(i - last), 32'd4);
        last = i;
      end
    end
    check("run_first", 32'(first), 32'd4);
    check("run_pulses", 32'(pulses), 32'd10);
    tick();
    check("run_count", 32'(stepCount), 32'd10);
    nStep = 1'b0;
    for (int i = 0; i < 40 && !paused; i++) tick();
    check("pause_seen", 32'(paused), 32'd1);
    nStep = 1'b1; pulses = 0;
    repeat (20) begin tick(); if (cpuStep) pulses++; end
    check("pause_pulses", 32'(pulses), 32'd0);
    check("pause_held", 32'(paused), 32'd1);
    nStep = 1'b0;
    for (int i = 0; i < 40 && paused; i++) tick();
    check("resume_seen", 32'(paused), 32'd0);
    nStep = 1'b1; pulses = 0;
    repeat (20) begin tick(); if (cpuStep) pulses++; end
    check("resume_pulses", 32'(pulses), 32'd5);

    // Reset while paused with stepCount = 7
    rst = 1'b1; nStep = 1'b1; tick(); rst = 1'b0;
    modeRun = 1'b1;
    repeat (11) tick();
    nStep = 1'b0;
    repeat (23) tick();
    check("pre_rst_paused", 32'(paused), 32'd1);
    check("pre_rst_count", 32'(stepCount), 32'd7);
    rst = 1'b1;
    tick();
    check("mid_rst_cpuStep", 32'(cpuStep), 32'd0);
    check("mid_rst_paused", 32'(paused), 32'd0);
    check("mid_rst_count", 32'(stepCount), 32'd0);
    check("mid_rst_digit", 32'(digit), 32'd0);
    check("mid_rst_blank", 32'(blank), 32'd0);
    rst = 1'b0; nStep = 1'b1; first = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (cpuStep && first == 0) first = i;
    end
    check("post_rst_first", 32'(first), 32'(RUN_DIV));

    // Press coinciding with leaving run mode is a step-mode press
    rst = 1'b1; tick(); rst = 1'b0;
    modeRun = 1'b1; nStep = 1'b0;
    repeat (18) tick();
    modeRun = 1'b0;
    tick();
    check("exit_run_step", 32'(cpuStep), 32'd1);
    check("exit_run_paused", 32'(paused), 32'd0);
    nStep = 1'b1;
    repeat (30) tick();

    // stepCount wrap
    modeRun = 1'b0;
    repeat (3) tick();
    force dut.stepCount = 16'hFFFF;
    #1;
    release dut.stepCount;
    m_count = 16'hFFFF;
    modeRun = 1'b1;
    first = 0;
    for (int i = 0; i < 10 && first == 0; i++) begin
      tick();
      if (cpuStep) first = 1;
    end
    check("wrap_pulse_seen", 32'(first), 32'd1);
    tick();
    check("wrap_count", 32'(stepCount), 32'd0);

    // Randomized traffic against the model
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        nStep = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 40));
      end
      hold--;
      if ($urandom_range(0, 149) == 0) modeRun = ~modeRun;
      rst = ($urandom_range(0, 599) == 0);
      sel = 2'($urandom_range(0, 3));
      blankEn = 1'($urandom_range(0, 1));
      result = N'($urandom);
      pc = P_SIZE'($urandom);
      if ($urandom_range(0, 3) == 0) result = '0;
      if ($urandom_range(0, 3) == 0) pc = '0;
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/front_panel.md
FRONT_PANEL -- requirements
Module: front_panel

Interface
REQ-001 SHALL have parameter N, default 8, CPU result width (1..16).
REQ-002 SHALL have parameter P_SIZE, default 8, program-counter width (1..16).
REQ-003 SHALL have parameter DIGITS, default 6, hex display digit count (4..8).
REQ-004 SHALL have parameter DEB_CYCLES, default 16, debounce stability period in clocks (>=2).
REQ-005 SHALL have parameter RUN_DIV, default 4, run-mode step period in clocks (>=2).
REQ-006 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port nStep  input  1  raw step button, asynchronous, low = pressed.
REQ-009 SHALL have port modeRun  input  1  0 = single-step mode, 1 = free-run mode.
REQ-010 SHALL have port sel  input  2  display source select.
REQ-011 SHALL have port blankEn  input  1  leading-zero blanking enable.
REQ-012 SHALL have port result  input  N  CPU result value.
REQ-013 SHALL have port pc  input  P_SIZE  CPU program counter.
REQ-014 SHALL have port cpuStep  output  1  one-cycle CPU advance enable.
REQ-015 SHALL have port paused  output  1  run mode currently paused.
REQ-016 SHALL have port stepCount  output  16  count of issued cpuStep pulses.
REQ-017 SHALL have port digit  output  DIGITS*4  hex nibbles, digit 0 in bits [3:0].
REQ-018 SHALL have port blank  output  DIGITS  per-digit blank flags, 1 = dark.

Function
REQ-019 nStep SHALL pass through a 2-flop synchroniser before any use.
REQ-020 Debouncer SHALL hold stable level (reset = released) and a counter; counter clears whenever synchronised level equals stable level, else increments; on reaching DEB_CYCLES-1 while still differing, stable level SHALL flip and counter clear.
REQ-021 A press event SHALL be a single-cycle pulse on the released->pressed flip of stable level; release flips SHALL produce no event.
REQ-022 Step mode: each press event SHALL produce exactly one cpuStep pulse on the following cycle; divider held at 0.
REQ-023 Run mode, not paused: divider SHALL count 0..RUN_DIV-1 and wrap; cpuStep SHALL be high the cycle after divider equals RUN_DIV-1, i.e. one pulse per RUN_DIV clocks.
REQ-024 Run mode: each press event SHALL toggle paused; while paused, divider holds and no cpuStep is issued; resume continues from held divider value.
REQ-025 modeRun 1->0 SHALL clear paused and divider in the same cycle; a press event coinciding with that change SHALL be treated as step mode.
REQ-026 cpuStep SHALL never be high on two consecutive cycles.
REQ-027 stepCount SHALL increment by 1 on each cpuStep cycle, wrapping 0xFFFF->0x0000.
REQ-028 Display source value: sel=0 result; sel=1 pc; sel=2 stepCount; sel=3 {pc,result} with result in low bits; zero-extended or truncated to DIGITS*4 bits.
REQ-029 digit SHALL register the source value with 1-cycle latency from any input change.
REQ-030 With blankEn=1, blank[i] SHALL be 1 for each i>=1 such that digit i and all higher digits are zero; blank[0] SHALL always be 0; with blankEn=0 blank SHALL be all 0; blank registered alongside digit.

Reset
REQ-031 rst SHALL, on the next clock edge, set cpuStep=0, paused=0, stepCount=0, digit=0, blank=0, divider=0, debounce counter=0, stable level=released, synchroniser flops=released.
REQ-032 rst SHALL override all other inputs, including a mid-debounce press or mid-period run; no cpuStep SHALL be issued in the cycle following reset release.

Verification
REQ-033 Step mode, DEB_CYCLES=16: nStep low for 40 clocks then high -> exactly one cpuStep, stepCount=1.
REQ-034 Step mode: nStep glitches low for 10 clocks, 5 times -> no cpuStep, stepCount=0.
REQ-035 Run mode, RUN_DIV=4, 40 clocks -> 10 cpuStep pulses spaced 4 apart, stepCount=10; press -> paused=1, no pulses for 20 clocks; press -> pulses resume.
REQ-036 sel=3, pc=0x12, result=0x34, DIGITS=6, blankEn=1 -> digit=0x001234 one cycle later, blank=6'b110000; result=0, pc=0, sel=0 -> blank=6'b111110.
REQ-037 stepCount preloaded to 0xFFFF via 65535 run-mode steps, one more step -> stepCount=0x0000.
REQ-038 rst asserted mid-run with paused=1 and stepCount=7 -> all outputs zero next cycle, paused=0, first pulse RUN_DIV clocks after release.
